// File: rtl/alu_param_pipe_if.sv
// Handshake/data bundle for alu_param_pipe: operand request channel in, result/flag channel out.
`timescale 1ns/1ps
interface alu_param_pipe_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic [SHW-1:0]   shiftValue;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carryFlag;
  logic             zeroFlag;
  logic             overFlowFlag;
  logic             signFlag;
  logic             divZeroFlag;

  modport master (
    output in_valid, opcode, input1, input2, shiftValue, out_ready,
    input  in_ready, out_valid, result, carryFlag, zeroFlag, overFlowFlag, signFlag, divZeroFlag
  );

  modport slave (
    input  in_valid, opcode, input1, input2, shiftValue, out_ready,
    output in_ready, out_valid, result, carryFlag, zeroFlag, overFlowFlag, signFlag, divZeroFlag
  );
endinterface

// File: rtl/alu_param_pipe.sv
// Two-stage ALU: S1 holds operands (and runs the iterative divider), S2 holds result and flags.
`timescale 1ns/1ps
module alu_param_pipe #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  alu_param_pipe_if.slave     bus,
  output logic [1:0]          dbg_state
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_INIT = SHW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_DIV  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_MIN  = 4'd9;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} div_state_t;

  div_state_t       state, state_next;
  logic [SHW-1:0]   count;
  logic [WIDTH-1:0] rem, quo;
  logic [WIDTH:0]   trial, div_diff;

  logic             s1_valid;
  logic [3:0]       s1_op;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [SHW-1:0]   s1_sh;
  logic             s1_done, s1_advance, accept, accept_div;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q, zero_q, over_q, sign_q, divz_q;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry, alu_over, alu_divz;
  logic [WIDTH:0]     sum, sub_diff;
  logic [2*WIDTH-1:0] prod;

  // Valid/ready: a beat moves on a channel only in a cycle where valid and ready are both
  // high at the rising edge; valid, once raised, holds its payload stable until that beat.
  assign s1_done    = s1_valid && ((s1_op != OP_DIV) || (state == DONE));
  assign s1_advance = s1_done && (!out_valid_q || bus.out_ready);
  assign bus.in_ready = !s1_valid || s1_advance;
  assign accept     = bus.in_valid && bus.in_ready;
  assign accept_div = accept && (bus.opcode == OP_DIV);

  assign bus.out_valid    = out_valid_q;
  assign bus.result       = result_q;
  assign bus.carryFlag    = carry_q;
  assign bus.zeroFlag     = zero_q;
  assign bus.overFlowFlag = over_q;
  assign bus.signFlag     = sign_q;
  assign bus.divZeroFlag  = divz_q;
  assign dbg_state        = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A new DIV can only be accepted from IDLE or from a DONE that is advancing this cycle.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (count == '0) state_next = DONE;
      DONE:    if (s1_advance) state_next = IDLE;
      default: ;
    endcase
    if (accept_div) state_next = (bus.input2 == '0) ? DONE : RUN;
  end

  assign trial    = {rem, quo[WIDTH-1]};
  assign div_diff = trial - {1'b0, s1_b};

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      rem   <= '0;
      quo   <= '0;
    end else if (accept_div) begin
      count <= CNT_INIT;
      rem   <= '0;
      quo   <= (bus.input2 == '0) ? '0 : bus.input1;
    end else if (state == RUN) begin
      if (count != '0) count <= count - SHW'(1);
      rem <= div_diff[WIDTH] ? trial[WIDTH-1:0] : div_diff[WIDTH-1:0];
      quo <= {quo[WIDTH-2:0], ~div_diff[WIDTH]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sh    <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_op    <= bus.opcode;
      s1_a     <= bus.input1;
      s1_b     <= bus.input2;
      s1_sh    <= bus.shiftValue;
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  assign sum      = {1'b0, s1_a} + {1'b0, s1_b};
  assign sub_diff = {1'b0, s1_a} - {1'b0, s1_b};
  assign prod     = {{WIDTH{1'b0}}, s1_a} * {{WIDTH{1'b0}}, s1_b};

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_over  = 1'b0;
    alu_divz  = 1'b0;
    case (s1_op)
      OP_ADD: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_over  = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = sub_diff[WIDTH-1:0];
        alu_carry = sub_diff[WIDTH];
        alu_over  = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (sub_diff[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_MUL: begin
        alu_res   = prod[WIDTH-1:0];
        alu_carry = |prod[2*WIDTH-1:WIDTH];
      end
      OP_XOR:  alu_res = s1_a ^ s1_b;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (s1_a < s1_b)};
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
      OP_SLL:  alu_res = s1_a << s1_sh;
      OP_SRL:  alu_res = s1_a >> s1_sh;
      OP_MIN:  alu_res = (s1_a <= s1_b) ? s1_a : s1_b;
      OP_DIV: begin
        alu_res  = quo;
        alu_divz = (s1_b == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      over_q      <= 1'b0;
      sign_q      <= 1'b0;
      divz_q      <= 1'b0;
    end else if (s1_advance) begin
      out_valid_q <= 1'b1;
      result_q    <= alu_res;
      carry_q     <= alu_carry;
      zero_q      <= (alu_res == '0);
      over_q      <= alu_over;
      sign_q      <= alu_res[WIDTH-1];
      divz_q      <= alu_divz;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_param_pipe.sv
// Bench for alu_param_pipe at WIDTH 8, 32 and 128: fixed vectors, random traffic, streaming and reset cases.
`timescale 1ns/1ps
module tb_alu_param_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_param_pipe_if #(.WIDTH(8))   if8 ();
  alu_param_pipe_if #(.WIDTH(32))  if32 ();
  alu_param_pipe_if #(.WIDTH(128)) if128 ();
  logic [1:0] st8, st32, st128;

  alu_param_pipe #(.WIDTH(8))   u8   (.clk(clk), .rst(rst), .bus(if8),   .dbg_state(st8));
  alu_param_pipe #(.WIDTH(32))  u32  (.clk(clk), .rst(rst), .bus(if32),  .dbg_state(st32));
  alu_param_pipe #(.WIDTH(128)) u128 (.clk(clk), .rst(rst), .bus(if128), .dbg_state(st128));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: arithmetic on wide integers, masked to the operating width.
  typedef struct packed {
    logic [255:0] res;
    logic c, z, o, s, dz;
  } model_t;

  function automatic model_t model(input int w, input logic [3:0] op,
                                   input logic [255:0] a_in, input logic [255:0] b_in, input int sh);
    model_t m;
    logic [255:0] mask, a, b, r, full;
    logic sa, sb;
    m = '0;
    r = '0;
    mask = (256'd1 << w) - 256'd1;
    a = a_in & mask;
    b = b_in & mask;
    sa = a[w-1];
    sb = b[w-1];
    case (op)
      4'd0: begin full = a + b; r = full & mask; m.c = full[w]; m.o = (sa == sb) && (r[w-1] != sa); end
      4'd1: begin r = (a - b) & mask; m.c = (a < b); m.o = (sa != sb) && (r[w-1] != sa); end
      4'd2: begin full = a * b; r = full & mask; m.c = ((full >> w) != 256'd0); end
      4'd3: r = a ^ b;
      4'd4: r = (a < b) ? 256'd1 : 256'd0;
      4'd5: r = (a << sh) & mask;
      4'd6: r = ((sa != sb) ? sa : (a < b)) ? 256'd1 : 256'd0;
      4'd7: begin if (b == 256'd0) begin r = '0; m.dz = 1'b1; end else r = a / b; end
      4'd8: r = a >> sh;
      4'd9: r = (a <= b) ? a : b;
      default: r = '0;
    endcase
    m.res = r;
    m.z = (r == 256'd0);
    m.s = r[w-1];
    return m;
  endfunction

  // One op on the 8-bit instance; lat counts cycles from the accept cycle (=1) to out_valid.
  task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [2:0] sh,
                      output logic [7:0] res, output logic [4:0] fl, output int lat, output int ir_high);
    int t;
    if8.opcode = op; if8.input1 = a; if8.input2 = b; if8.shiftValue = sh;
    if8.in_valid = 1'b1; if8.out_ready = 1'b1;
    t = 0;
    @(negedge clk);
    while (!if8.in_ready && t < 50) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    lat = 1; ir_high = 0;
    while (lat < 200) begin
      @(negedge clk);
      if (if8.out_valid) break;
      if (if8.in_ready && lat <= 8) ir_high++;
      @(posedge clk);
      lat++;
    end
    res = if8.result;
    fl = {if8.carryFlag, if8.zeroFlag, if8.overFlowFlag, if8.signFlag, if8.divZeroFlag};
    @(posedge clk); #1;
  endtask

  task automatic run128(input logic [3:0] op, input logic [127:0] a, input logic [127:0] b, input logic [6:0] sh,
                        output logic [127:0] res, output logic [4:0] fl);
    int t;
    if128.opcode = op; if128.input1 = a; if128.input2 = b; if128.shiftValue = sh;
    if128.in_valid = 1'b1; if128.out_ready = 1'b1;
    t = 0;
    @(negedge clk);
    while (!if128.in_ready && t < 50) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    if128.in_valid = 1'b0;
    t = 0;
    @(negedge clk);
    while (!if128.out_valid && t < 300) begin @(negedge clk); t++; end
    check("w128_timeout", 256'(t >= 300), 256'd0);
    res = if128.result;
    fl = {if128.carryFlag, if128.zeroFlag, if128.overFlowFlag, if128.signFlag, if128.divZeroFlag};
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] a, b;
    logic [2:0] sh;
    logic [7:0] res;
    logic [4:0] fl;   // {carry, zero, overflow, sign, divzero}
    int         lat;
  } vec_t;

  vec_t vt[18];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]   r8;
    logic [4:0]   f8;
    int           lat, irh, ov;
    model_t       m;
    logic [12:0]  exp_q[$];
    logic [12:0]  held, cur;
    logic [31:0]  q32[$];
    logic [31:0]  held32;
    logic [127:0] r128, one_hi, ra, rb;
    logic [4:0]   f128;

    vt[0]  = '{4'd0, 8'h7F, 8'h01, 3'd0, 8'h80, 5'b00110, 2};
    vt[1]  = '{4'd1, 8'h00, 8'h01, 3'd0, 8'hFF, 5'b10010, 2};
    vt[2]  = '{4'd6, 8'hFF, 8'h01, 3'd0, 8'h01, 5'b00000, 2};
    vt[3]  = '{4'd4, 8'hFF, 8'h01, 3'd0, 8'h00, 5'b01000, 2};
    vt[4]  = '{4'd7, 8'hC8, 8'h07, 3'd0, 8'h1C, 5'b00000, 10};
    vt[5]  = '{4'd7, 8'h05, 8'h00, 3'd0, 8'h00, 5'b01001, 2};
    vt[6]  = '{4'd0, 8'hFF, 8'h01, 3'd0, 8'h00, 5'b11000, 2};
    vt[7]  = '{4'd2, 8'h10, 8'h20, 3'd0, 8'h00, 5'b11000, 2};
    vt[8]  = '{4'd9, 8'h05, 8'h05, 3'd0, 8'h05, 5'b00000, 2};
    vt[9]  = '{4'd9, 8'h09, 8'h03, 3'd0, 8'h03, 5'b00000, 2};
    vt[10] = '{4'd5, 8'h81, 8'h00, 3'd1, 8'h02, 5'b00000, 2};
    vt[11] = '{4'd8, 8'h80, 8'h00, 3'd7, 8'h01, 5'b00000, 2};
    vt[12] = '{4'd12, 8'h03, 8'h04, 3'd0, 8'h00, 5'b01000, 2};
    vt[13] = '{4'd3, 8'hA5, 8'h5A, 3'd0, 8'hFF, 5'b00010, 2};
    vt[14] = '{4'd1, 8'h80, 8'h01, 3'd0, 8'h7F, 5'b00100, 2};
    vt[15] = '{4'd7, 8'hFF, 8'hFF, 3'd0, 8'h01, 5'b00000, 10};
    vt[16] = '{4'd2, 8'h0F, 8'h11, 3'd0, 8'hFF, 5'b00010, 2};
    vt[17] = '{4'd7, 8'h07, 8'hC8, 3'd0, 8'h00, 5'b01000, 10};

    if8.in_valid = 0;   if8.opcode = 0;   if8.input1 = 0;   if8.input2 = 0;   if8.shiftValue = 0;   if8.out_ready = 0;
    if32.in_valid = 0;  if32.opcode = 0;  if32.input1 = 0;  if32.input2 = 0;  if32.shiftValue = 0;  if32.out_ready = 0;
    if128.in_valid = 0; if128.opcode = 0; if128.input1 = 0; if128.input2 = 0; if128.shiftValue = 0; if128.out_ready = 0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 256'(if8.in_ready), 256'd1);
    check("rst_out_valid", 256'({if8.out_valid, if32.out_valid, if128.out_valid}), 256'd0);
    check("rst_result", 256'(if8.result), 256'd0);
    check("rst_flags", 256'({if8.carryFlag, if8.zeroFlag, if8.overFlowFlag, if8.signFlag, if8.divZeroFlag}), 256'd0);
    @(posedge clk); #1;

    // Fixed vectors
    for (int i = 0; i < 18; i++) begin
      run8(vt[i].op, vt[i].a, vt[i].b, vt[i].sh, r8, f8, lat, irh);
      check($sformatf("vec%0d_result", i), 256'(r8), 256'(vt[i].res));
      check($sformatf("vec%0d_flags", i), 256'(f8), 256'(vt[i].fl));
      check($sformatf("vec%0d_latency", i), 256'(lat), 256'(vt[i].lat));
      if (vt[i].op == 4'd7 && vt[i].b != 8'd0)
        check($sformatf("vec%0d_in_ready_low", i), 256'(irh), 256'd0);
    end

    // Reset during a divide
    if8.opcode = 4'd7; if8.input1 = 8'hC8; if8.input2 = 8'h07; if8.in_valid = 1'b1; if8.out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 if8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_div_in_ready", 256'(if8.in_ready), 256'd1);
    ov = 0;
    repeat (12) begin @(negedge clk); if (if8.out_valid) ov++; end
    check("rst_div_no_out", 256'(ov), 256'd0);
    @(posedge clk); #1;
    run8(4'd0, 8'h12, 8'h34, 3'd0, r8, f8, lat, irh);
    check("post_rst_add_result", 256'(r8), 256'h46);
    check("post_rst_add_latency", 256'(lat), 256'd2);

    // Reset while the output is stalled and S1 is full
    if8.out_ready = 1'b0;
    if8.opcode = 4'd0; if8.input1 = 8'h01; if8.input2 = 8'h01; if8.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 if8.in_valid = 1'b0;
    @(negedge clk);
    check("stall_fill_out_valid", 256'(if8.out_valid), 256'd1);
    check("stall_fill_in_ready", 256'(if8.in_ready), 256'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; if8.out_ready = 1'b1;
    ov = 0;
    repeat (6) begin @(negedge clk); if (if8.out_valid) ov++; end
    check("rst_stall_no_out", 256'(ov), 256'd0);
    @(posedge clk); #1;

    // Random traffic with random backpressure on the 8-bit instance
    begin
      int sent, got, cyc, hold_err;
      logic was_stall, fired;
      sent = 0; got = 0; cyc = 0; hold_err = 0; was_stall = 1'b0;
      if8.in_valid = 1'b0; if8.out_ready = 1'b1;
      while (cyc < 20000 && !(sent == 300 && exp_q.size() == 0)) begin
        @(negedge clk);
        cur = {if8.carryFlag, if8.zeroFlag, if8.overFlowFlag, if8.signFlag, if8.divZeroFlag, if8.result};
        if (was_stall && (!if8.out_valid || cur != held)) hold_err++;
        was_stall = 1'b0;
        if (if8.out_valid) begin
          if (if8.out_ready) begin
            if (exp_q.size() == 0) check("rand_unexpected_out", 256'd1, 256'd0);
            else check("rand_out", 256'(cur), 256'(exp_q.pop_front()));
            got++;
          end else begin
            was_stall = 1'b1;
            held = cur;
          end
        end
        fired = if8.in_valid && if8.in_ready;
        if (fired) begin
          m = model(8, if8.opcode, 256'(if8.input1), 256'(if8.input2), int'(if8.shiftValue));
          exp_q.push_back({m.c, m.z, m.o, m.s, m.dz, m.res[7:0]});
          sent++;
        end
        @(posedge clk); #1;
        cyc++;
        if (!if8.in_valid || fired) begin
          if (sent < 300 && $urandom_range(0, 3) != 0) begin
            if8.in_valid = 1'b1;
            if8.opcode = 4'($urandom_range(0, 15));
            if8.input1 = 8'($urandom);
            if8.input2 = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            if8.shiftValue = 3'($urandom_range(0, 7));
          end else begin
            if8.in_valid = 1'b0;
          end
        end
        if8.out_ready = ($urandom_range(0, 3) != 0);
      end
      check("rand_timeout", 256'(cyc >= 20000), 256'd0);
      check("rand_count", 256'(got), 256'd300);
      check("rand_hold", 256'(hold_err), 256'd0);
      if8.in_valid = 1'b0; if8.out_ready = 1'b1;
    end

    // 32-bit streaming XOR, then a 5-cycle output stall
    begin
      int acc, outs, cyc, stall, first_c, last_c, hold_err;
      logic prev_held, saw_block, fired;
      acc = 0; outs = 0; cyc = 0; stall = 0; first_c = 0; last_c = 0; hold_err = 0;
      prev_held = 1'b0; saw_block = 1'b0;
      if32.opcode = 4'd3; if32.input1 = $urandom; if32.input2 = $urandom;
      if32.in_valid = 1'b1; if32.out_ready = 1'b1;
      while (cyc < 300 && (acc < 20 || outs < acc)) begin
        @(negedge clk);
        if (if32.out_valid && !if32.out_ready) begin
          if (prev_held && if32.result != held32) hold_err++;
          held32 = if32.result;
          prev_held = 1'b1;
          if (!if32.in_ready) saw_block = 1'b1;
        end else begin
          prev_held = 1'b0;
        end
        if (if32.out_valid && if32.out_ready) begin
          if (q32.size() == 0) check("xor_unexpected_out", 256'd1, 256'd0);
          else check("xor_out", 256'(if32.result), 256'(q32.pop_front()));
          if (outs == 0) first_c = cyc;
          if (outs == 15) last_c = cyc;
          outs++;
        end
        fired = if32.in_valid && if32.in_ready;
        if (fired) begin
          q32.push_back(if32.input1 ^ if32.input2);
          acc++;
        end
        @(posedge clk); #1;
        cyc++;
        if (fired) begin
          if (acc < 20) begin if32.input1 = $urandom; if32.input2 = $urandom; end
          else if32.in_valid = 1'b0;
        end
        if (outs >= 16 && stall < 5) begin if32.out_ready = 1'b0; stall++; end
        else if32.out_ready = 1'b1;
      end
      check("xor_consecutive", 256'(last_c - first_c), 256'd15);
      check("xor_hold", 256'(hold_err), 256'd0);
      check("xor_in_ready_drop", 256'(saw_block), 256'd1);
      check("xor_count", 256'(outs), 256'd20);
      check("xor_queue_empty", 256'(q32.size()), 256'd0);
      if32.in_valid = 1'b0;
    end

    // 128-bit corner cases and random ops against the model
    one_hi = 128'd1 << 127;
    run128(4'd2, one_hi, 128'd2, 7'd0, r128, f128);
    check("w128_mul_result", 256'(r128), 256'd0);
    check("w128_mul_flags", 256'(f128), 256'(5'b11000));
    run128(4'd5, 128'd1, 128'd0, 7'd127, r128, f128);
    check("w128_sll_result", 256'(r128), 256'(one_hi));
    check("w128_sll_flags", 256'(f128), 256'(5'b00010));
    for (int i = 0; i < 20; i++) begin
      logic [3:0] op;
      logic [6:0] sh;
      op = 4'($urandom_range(0, 10));
      sh = 7'($urandom_range(0, 127));
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = ($urandom_range(0, 1) == 0) ? 128'($urandom) : {$urandom, $urandom, $urandom, $urandom};
      m = model(128, op, 256'(ra), 256'(rb), int'(sh));
      run128(op, ra, rb, sh, r128, f128);
      check($sformatf("w128_rand%0d_result", i), 256'(r128), m.res);
      check($sformatf("w128_rand%0d_flags", i), 256'(f128), 256'({m.c, m.z, m.o, m.s, m.dz}));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_param_pipe.md
ALU_PARAM_PIPE -- requirements
Module: alu_param_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width (legal values 8..128).
REQ-002 The block SHALL have derived localparam SHW, equal to clog2(WIDTH), giving the shift-amount width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 in_valid  input  1  opcode/operands presented.
REQ-006 in_ready  output  1  block can accept this cycle.
REQ-007 opcode  input  4  ADD=0 SUB=1 MUL=2 XOR=3 SLTU=4 SLL=5 SLT=6 DIV=7 SRL=8 MIN=9.
REQ-008 input1, input2  input  WIDTH  operands.
REQ-009 shiftValue  input  SHW  shift amount for SLL/SRL.
REQ-010 out_valid  output  1  result/flags valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  WIDTH  registered result.
REQ-013 carryFlag, zeroFlag, overFlowFlag, signFlag, divZeroFlag  output  1 each  registered flags, aligned with result.

Function
REQ-014 Transfers SHALL occur only on in_valid&&in_ready at the input and out_valid&&out_ready at the output.
REQ-015 The datapath SHALL have two stages: S1 (operand register, s1_valid) and S2 (result/flag register, driven as out_valid).
REQ-016 in_ready SHALL equal !s1_valid || s1_advance, where s1_advance = S1 holds a completed op && (!out_valid || out_ready).
REQ-017 Non-DIV ops SHALL complete in S1 in one cycle; a transfer accepted at edge N yields out_valid at edge N+2 when no backpressure is present.
REQ-018 Back-to-back non-DIV ops with out_ready=1 SHALL sustain one result per cycle.
REQ-019 While out_valid&&!out_ready, result, all flags and out_valid SHALL hold stable, and S1 SHALL stall without losing data.
REQ-020 ADD SHALL compute {carryFlag,result} = input1+input2 (WIDTH+1 bits); overFlowFlag = (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]), computed from the new sum, not the prior result.
REQ-021 SUB SHALL compute result = input1-input2; carryFlag = borrow (input1<input2 unsigned); overFlowFlag = (a[W-1]!=b[W-1]) && (diff[W-1]!=a[W-1]).
REQ-022 MUL SHALL output the low WIDTH bits of the unsigned product; carryFlag = 1 if any upper product bit is nonzero.
REQ-023 XOR SHALL compute bitwise XOR; SLL and SRL SHALL be logical shifts of input1 by shiftValue (0..WIDTH-1).
REQ-024 SLTU and SLT SHALL return result = {WIDTH-1 zeros, lt}, with unsigned and signed compare respectively.
REQ-025 MIN SHALL return the unsigned minimum; equal operands SHALL return input1.
REQ-026 DIV SHALL be an unsigned restoring iterative divider with FSM IDLE -> RUN (exactly WIDTH iterations, one per cycle, counter WIDTH-1 down to 0) -> DONE.
REQ-027 DONE SHALL be a completed op for S1 and SHALL return to IDLE on s1_advance.
REQ-028 With no backpressure, DIV out_valid SHALL occur WIDTH+2 cycles after acceptance.
REQ-029 in_ready SHALL be 0 from the DIV acceptance edge until s1_advance.
REQ-030 DIV with input2==0 SHALL skip RUN (IDLE -> DONE in 1 cycle) and yield result=0 and divZeroFlag=1.
REQ-031 For non-DIV ops divZeroFlag SHALL be 0.
REQ-032 Carry and overflow SHALL be 0 for every op that does not define them.
REQ-033 zeroFlag SHALL equal (result==0) and signFlag SHALL equal result[WIDTH-1], for all ops.
REQ-034 Undefined opcodes (10..15) SHALL be accepted and yield result 0, zeroFlag=1, all other flags 0.

Reset
REQ-035 On rst: s1_valid=0, out_valid=0, FSM=IDLE, iteration counter=0, result=0, all flags=0, in_ready=1 on the cycle after reset.
REQ-036 rst SHALL take priority over any handshake in the same cycle.
REQ-037 rst asserted mid-DIV or mid-stall SHALL discard all in-flight ops and produce no out_valid.

Verification
REQ-038 WIDTH=8, ADD 0x7F+0x01 -> result 0x80, overFlowFlag=1, signFlag=1, carryFlag=0, out_valid 2 cycles after accept.
REQ-039 WIDTH=8, SUB 0x00-0x01 -> result 0xFF, carryFlag=1, overFlowFlag=0; SLT 0xFF vs 0x01 -> result 1; SLTU -> result 0.
REQ-040 WIDTH=8, DIV 200/7 -> result 28, out_valid at accept+10, in_ready=0 throughout; DIV x/0 -> result 0, divZeroFlag=1, zeroFlag=1.
REQ-041 WIDTH=32, 16 back-to-back XOR ops, out_ready=1 -> 16 results on consecutive cycles; then out_ready=0 for 5 cycles -> result held, in_ready drops after S1 fills, no loss or duplication.
REQ-042 WIDTH=128, MUL (2^127)*2 -> result 0, carryFlag=1, zeroFlag=1; SLL 1 by 127 -> result 2^127, signFlag=1.
REQ-043 rst pulsed at DIV iteration 3 -> out_valid stays 0, in_ready=1 next cycle, a following ADD completes normally.
